// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: load handshake and display-drive signals of the
// four-digit seven-segment scan controller. The slave modport is the
// controller; the master modport is the upstream value source / board side.
interface display_scan_ctrl_if;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load_ack;
  logic        frame_tick;
  logic [1:0]  digit_sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport slave (
    input  load,
    input  value_in,
    input  dp_in,
    output load_ack,
    output frame_tick,
    output digit_sel,
    output an,
    output seg,
    output dp
  );

  modport master (
    output load,
    output value_in,
    output dp_in,
    input  load_ack,
    input  frame_tick,
    input  digit_sel,
    input  an,
    input  seg,
    input  dp
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: four-digit multiplexed seven-segment scan controller.
// A prescaler splits time into SCAN_DIV-cycle slots; digits are scanned
// 3,2,1,0 and each slot opens with BLANK_CYC cycles of all anodes off to
// hide ghosting. Values arrive through a load handshake into a pending
// register and are committed to the display only at frame boundaries.
// All outputs are registered and derived from next-state values so that
// they line up with the prescaler count with no lag.
// Optional feature: define SCAN_LEAD_ZERO_BLANK_EN to suppress leading
// zero digits (digits 3..1) during the drive phase.
module display_scan_ctrl #(
  parameter int SCAN_DIV  = 6750,
  parameter int BLANK_CYC = 64
) (
  input  logic               clk_27Mhz,
  input  logic               rst_n,
  display_scan_ctrl_if.slave bus
);

  // Wide enough for the largest legal slot length (2^20 cycles).
  localparam int CW = 20;

  // Scan state
  logic [CW-1:0] r_presc;
  logic [1:0]    r_sel;

  // Display and pending storage
  logic [15:0]   r_disp_val;
  logic [3:0]    r_disp_dp;
  logic [15:0]   r_pend_val;
  logic [3:0]    r_pend_dp;
  logic          r_pend_flag;

  // Registered outputs
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_ack;
  logic          r_tick;

  // Next-state helpers
  logic          w_wrap;
  logic          w_boundary;
  logic          w_commit;
  logic [CW-1:0] w_presc_next;
  logic [1:0]    w_sel_next;
  logic [15:0]   w_disp_val_next;
  logic [3:0]    w_disp_dp_next;
  logic [3:0]    w_nibs [4];
  logic [3:0]    w_onecold;
  logic [3:0]    w_lz;
  logic          w_blank;
  logic          w_supp;
  logic [3:0]    w_an_next;
  logic [6:0]    w_seg_next;
  logic          w_dp_next;

  // Active-low gfedcba decode of one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Slot timing: prescaler wraps at SCAN_DIV-1, digit index counts down and
  // naturally wraps 0 -> 3, which is the frame boundary.
  assign w_wrap       = (r_presc == CW'(SCAN_DIV - 1));
  assign w_presc_next = w_wrap ? '0 : r_presc + CW'(1);
  assign w_sel_next   = w_wrap ? r_sel - 2'd1 : r_sel;
  assign w_boundary   = w_wrap && (r_sel == 2'd0);

  // A commit only happens at a boundary with something pending; a load in
  // that same cycle goes to pending and never bypasses into the display.
  assign w_commit        = w_boundary && r_pend_flag;
  assign w_disp_val_next = w_commit ? r_pend_val : r_disp_val;
  assign w_disp_dp_next  = w_commit ? r_pend_dp  : r_disp_dp;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign w_nibs[gi]    = w_disp_val_next[4*gi +: 4];
      assign w_onecold[gi] = (w_sel_next != 2'(gi));
`ifdef SCAN_LEAD_ZERO_BLANK_EN
      if (gi == 0) begin : g_units
        // The units digit always shows, so a zero value still reads "0".
        assign w_lz[gi] = 1'b0;
      end else begin : g_lead
        // Suppressed when this nibble and everything to its left is zero.
        assign w_lz[gi] = ~|w_disp_val_next[15:4*gi];
      end
`else
      assign w_lz[gi] = 1'b0;
`endif
    end
  endgenerate

  assign w_blank    = (w_presc_next < CW'(BLANK_CYC));
  assign w_supp     = w_lz[w_sel_next];
  assign w_an_next  = (w_blank || w_supp) ? 4'hF : w_onecold;
  assign w_seg_next = w_blank ? 7'h7F : hex7(w_nibs[w_sel_next]);
  assign w_dp_next  = (w_blank || w_supp) ? 1'b1 : ~w_disp_dp_next[w_sel_next];

  // Advance the prescaler and the descending digit index.
  always_ff @(posedge clk_27Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_sel   <= 2'd3;
    end else begin
      r_presc <= w_presc_next;
      r_sel   <= w_sel_next;
    end
  end

  // Capture loads into pending and commit pending to the display at frame boundaries.
  always_ff @(posedge clk_27Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_val  <= '0;
      r_disp_dp   <= '0;
      r_pend_val  <= '0;
      r_pend_dp   <= '0;
      r_pend_flag <= 1'b0;
    end else begin
      r_disp_val <= w_disp_val_next;
      r_disp_dp  <= w_disp_dp_next;
      if (bus.load) begin
        r_pend_val  <= bus.value_in;
        r_pend_dp   <= bus.dp_in;
        r_pend_flag <= 1'b1;
      end else if (w_boundary) begin
        r_pend_flag <= 1'b0;
      end
    end
  end

  // Register the drive outputs and the one-cycle boundary pulses.
  always_ff @(posedge clk_27Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_an   <= 4'hF;
      r_seg  <= 7'h7F;
      r_dp   <= 1'b1;
      r_ack  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_an   <= w_an_next;
      r_seg  <= w_seg_next;
      r_dp   <= w_dp_next;
      r_ack  <= w_commit;
      r_tick <= w_boundary;
    end
  end

  assign bus.digit_sel  = r_sel;
  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.load_ack   = r_ack;
  assign bus.frame_tick = r_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench for display_scan_ctrl with
// SCAN_DIV=8, BLANK_CYC=2 (frame = 32 cycles). The stimulus pushes one
// expected-frame record per load/observation; the monitor pops a record at
// each frame_tick and checks every cycle of that frame.
module tb_display_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_scan_ctrl_if bus();

  display_scan_ctrl #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk_27Mhz (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0100001;

  // One expected frame: ack at the tick, per-digit segments, per-digit dp
  // output level while driven, and which digits keep their anode off.
  typedef struct packed {
    logic            ack;
    logic [3:0][6:0] seg;
    logic [3:0]      dp;
    logic [3:0]      supp;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic ack, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic [3:0] dp, input logic [3:0] supp);
    exp_t e;
    e.ack    = ack;
    e.seg[3] = s3;
    e.seg[2] = s2;
    e.seg[1] = s1;
    e.seg[0] = s0;
    e.dp     = dp;
    e.supp   = supp;
    return e;
  endfunction

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.frame_tick) got = 1'b1;
    end
    chk("frame_tick_seen", 32'(got), 32'd1);
  endtask

  // Load lasts one cycle; returns one negedge later.
  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bus.load     = 1'b1;
    bus.value_in = v;
    bus.dp_in    = d;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  // Monitor: frame position pos=0 is the frame_tick cycle.
  initial begin : monitor
    exp_t       cur;
    bit         active = 1'b0;
    bit         first  = 1'b1;
    int         pos    = 0;
    int         slot;
    int         cnt;
    logic [3:0] want_an;
    bit         off;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        first  = 1'b1;
        pos    = 0;
        continue;
      end
      if (bus.frame_tick) begin
        if (!first) chk("tick_period", 32'(pos), 32'd31);
        first = 1'b0;
        pos   = 0;
        if (exp_q.size() > 0) begin
          cur    = exp_q.pop_front();
          active = 1'b1;
          chk("load_ack_at_tick", 32'(bus.load_ack), 32'(cur.ack));
        end else begin
          active = 1'b0;
        end
      end else begin
        pos++;
        chk("ack_without_tick", 32'(bus.load_ack), 32'd0);
      end
      if (active && pos < 32) begin
        slot = 3 - pos / 8;
        cnt  = pos % 8;
        off  = (cnt < 2) || cur.supp[slot];
        want_an = 4'hF;
        if (!off) want_an[slot] = 1'b0;
        chk("digit_sel", 32'(bus.digit_sel), 32'(slot));
        chk("an", 32'(bus.an), 32'(want_an));
        chk("dp", 32'(bus.dp), off ? 32'd1 : 32'(cur.dp[slot]));
        if (cnt < 2)
          chk("seg_blank", 32'(bus.seg), 32'h7F);
        else if (!cur.supp[slot])
          chk("seg_drive", 32'(bus.seg), 32'(cur.seg[slot]));
      end
    end
  end

  initial begin : stim
    logic [3:0] m_dp;
    logic [3:0] m_supp;
`ifdef SCAN_LEAD_ZERO_BLANK_EN
    m_dp   = 4'b1110;
    m_supp = 4'b1110;
`else
    m_dp   = 4'b0000;
    m_supp = 4'b0000;
`endif
    bus.load     = 1'b0;
    bus.value_in = '0;
    bus.dp_in    = '0;
    rst_n        = 1'b0;
    adv(3);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'd1);
    chk("rst_sel", 32'(bus.digit_sel), 32'd3);
    chk("rst_ack", 32'(bus.load_ack), 32'd0);
    chk("rst_tick", 32'(bus.frame_tick), 32'd0);
    rst_n = 1'b1;
    adv(1);
    chk("rel_an_cnt1", 32'(bus.an), 32'hF);
    chk("rel_sel", 32'(bus.digit_sel), 32'd3);
    adv(1);
    chk("rel_an_cnt2", 32'(bus.an), 32'b0111);
    chk("rel_seg_cnt2", 32'(bus.seg), 32'(S0));
    chk("rel_dp_cnt2", 32'(bus.dp), 32'd1);

    // Scan: 1234 with digit 2 decimal point.
    wait_tick(); adv(5);
    exp_q.push_back(mk(1'b1, S1, S2, S3, S4, 4'b1011, 4'b0000));
    do_load(16'h1234, 4'b0100);

    // Handshake: ABCD loaded mid-frame, current frame keeps 1234.
    wait_tick(); adv(5);
    exp_q.push_back(mk(1'b1, SA, SB, SC, SD, 4'b1111, 4'b0000));
    do_load(16'hABCD, 4'b0000);
    wait_tick(); adv(1);
    exp_q.push_back(mk(1'b0, SA, SB, SC, SD, 4'b1111, 4'b0000));

    // Overwrite: 1111 then 2222 in one frame, single ack.
    wait_tick(); adv(3);
    do_load(16'h1111, 4'b0001);
    adv(6);
    exp_q.push_back(mk(1'b1, S2, S2, S2, S2, 4'b1101, 4'b0000));
    do_load(16'h2222, 4'b0010);
    wait_tick(); adv(1);
    exp_q.push_back(mk(1'b0, S2, S2, S2, S2, 4'b1101, 4'b0000));

    // Boundary collision with pending set.
    wait_tick(); adv(5);
    exp_q.push_back(mk(1'b1, S3, S3, S3, S3, 4'b1111, 4'b0000));
    do_load(16'h3333, 4'b0000);
    adv(25);
    exp_q.push_back(mk(1'b1, S4, S4, S4, S4, 4'b0111, 4'b0000));
    do_load(16'h4444, 4'b1000);
    wait_tick(); adv(1);
    exp_q.push_back(mk(1'b0, S4, S4, S4, S4, 4'b0111, 4'b0000));

    // Boundary load with pending clear: waits one extra frame, ack later.
    wait_tick(); adv(31);
    exp_q.push_back(mk(1'b0, S4, S4, S4, S4, 4'b0111, 4'b0000));
    exp_q.push_back(mk(1'b1, S5, S6, S7, S8, 4'b1111, 4'b0000));
    do_load(16'h5678, 4'b0000);
    wait_tick(); adv(5);

    // Leading zeros: 0005 with all decimal points requested.
    exp_q.push_back(mk(1'b1, S0, S0, S0, S5, m_dp, m_supp));
    do_load(16'h0005, 4'b1111);
    wait_tick();
    wait_tick();

    // Reset mid-DRIVE with a value pending.
    adv(3);
    do_load(16'h9999, 4'b0000);
    adv(8);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_an", 32'(bus.an), 32'hF);
    chk("mid_rst_seg", 32'(bus.seg), 32'h7F);
    chk("mid_rst_dp", 32'(bus.dp), 32'd1);
    chk("mid_rst_sel", 32'(bus.digit_sel), 32'd3);
    chk("mid_rst_ack", 32'(bus.load_ack), 32'd0);
    chk("mid_rst_tick", 32'(bus.frame_tick), 32'd0);
    adv(2);
    rst_n = 1'b1;
    adv(1);
    chk("mid_rel_an_cnt1", 32'(bus.an), 32'hF);
    adv(1);
    chk("mid_rel_an_cnt2", 32'(bus.an), 32'b0111);
    adv(24);
    chk("mid_rel_slot0_an", 32'(bus.an), 32'b1110);
    chk("mid_rel_slot0_seg", 32'(bus.seg), 32'(S0));
    wait_tick();
    chk("mid_rel_no_ack", 32'(bus.load_ack), 32'd0);
    adv(2);
    chk("mid_rel_next_seg", 32'(bus.seg), 32'(S0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
